// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module apb_rr_picker
  import apb_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int IW   = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] win_o,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o
);

  always_comb begin
    int c;
    c       = 0;
    win_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      c = int'(ptr_i) + i;
      if (c >= N_REQ) c = c - N_REQ;
      if (!valid_o && req_i[c]) begin
        valid_o = 1'b1;
        idx_o   = IW'(c);
      end
    end
    win_o[idx_o] = valid_o;
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among N_REQ req/gnt/rsp requesters.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [N_REQ-1:0]            we_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [N_REQ-1:0]            gnt_o,
  output logic [N_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]       rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic [ADDR_WIDTH-1:0]       paddr_o,
  output logic                        psel_o,
  output logic                        penable_o,
  output logic                        pwrite_o,
  output logic [DATA_WIDTH-1:0]       pwdata_o,
  input  logic                        pready_i,
  input  logic [DATA_WIDTH-1:0]       prdata_i,
  input  logic                        pslverr_i
);

  localparam int IW = idx_width(N_REQ);
  // A disabled timeout still needs a 1-bit counter to keep the declarations legal.
  localparam int CW = (CNT_WIDTH > 0) ? CNT_WIDTH : 1;

  state_e                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          own_q, own_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   we_q, we_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [N_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic [N_REQ-1:0]       win;
  logic [IW-1:0]          win_idx;
  logic                   win_vld;
  logic                   timeout, done, arb;

  apb_rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .win_o   (win),
    .idx_o   (win_idx),
    .valid_o (win_vld)
  );

  // Fires on the last allowed ACCESS cycle; pready in that cycle still wins.
  assign timeout = (TIMEOUT_CYCLES != 0) && (state_q == ACCESS) && !pready_i &&
                   (int'(cnt_q) == TIMEOUT_CYCLES - 1);
  assign done    = (state_q == ACCESS) && (pready_i || timeout);
  assign arb     = (state_q == IDLE) || done;

  assign gnt_o       = arb ? win : '0;
  assign psel_o      = (state_q != IDLE);
  assign penable_o   = (state_q == ACCESS);
  assign paddr_o     = addr_q;
  assign pwrite_o    = we_q;
  assign pwdata_o    = wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    own_d       = own_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rsp_valid_d = '0;
    rdata_d     = '0;
    err_d       = 1'b0;

    if (done) begin
      rsp_valid_d[own_q] = 1'b1;
      err_d              = pready_i ? pslverr_i : 1'b1;
      if (pready_i && !we_q) rdata_d = prdata_i;
    end

    case (state_q)
      SETUP:   state_d = ACCESS;
      ACCESS:  if (!done && TIMEOUT_CYCLES != 0) cnt_d = cnt_q + 1'b1;
      default: ;
    endcase

    // Completion and a new grant share the cycle, so ACCESS can go straight to SETUP.
    if (arb) begin
      if (win_vld) begin
        state_d = SETUP;
        own_d   = win_idx;
        ptr_d   = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
        cnt_d   = '0;
        addr_d  = addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        we_d    = we_i[win_idx];
        wdata_d = wdata_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      own_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      own_q       <= own_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench: requester/slave model predicts grants, bus phases and responses.
module tb_apb_master_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, we, gnt, rsp_valid;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rsp_rdata, pwdata, prdata;
  logic            rsp_err, psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0]   paddr;

  always #5 clk = ~clk;

  apb_master_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata),
    .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );

  typedef struct {int id; logic [AW-1:0] a; logic w; logic [DW-1:0] d;} xfer_t;
  typedef struct {int id; logic [DW-1:0] rd; logic err; longint t;} rsp_t;

  rsp_t  exp_q[$];
  int    checks = 0, errors = 0;
  xfer_t pend[N];
  bit    pend_v[N];
  xfer_t cur;
  // Bus view of the model: 0 idle, 1 setup, 2 access.
  int    phase = 0, acc_cnt = 0, ptr_m = 0;
  int    req_pct = 0, rdy_pct = 100, err_pct = 0, hold_pct = 0, wd_pct = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mk(input int i, input logic [AW-1:0] a, input bit w, input logic [DW-1:0] d);
    pend[i] = '{i, a, w, d};
    pend_v[i] = 1'b1;
  endtask

  task automatic cycle(input bit do_rst = 1'b0);
    bit done, arb;
    int w;
    logic [N-1:0] eg;
    @(negedge clk);
    chk("psel", psel, phase != 0);
    chk("penable", penable, phase == 2);
    if (phase != 0) begin
      chk("paddr", paddr, cur.a);
      chk("pwrite", pwrite, cur.w);
      if (cur.w) chk("pwdata", pwdata, cur.d);
    end
    for (int i = 0; i < N; i++) begin
      if (!pend_v[i] && $urandom_range(99) < req_pct)
        mk(i, $urandom, 1'($urandom_range(1)), $urandom);
      else if (pend_v[i] && $urandom_range(99) < wd_pct)
        pend_v[i] = 1'b0;
      req[i] = pend_v[i];
      addr[i*AW +: AW]  = pend[i].a;
      we[i]             = pend[i].w;
      wdata[i*DW +: DW] = pend[i].d;
    end
    pready  = ($urandom_range(99) < rdy_pct);
    prdata  = $urandom;
    pslverr = ($urandom_range(99) < err_pct);
    rst     = do_rst;
    #1;
    if (do_rst) begin
      phase = 0; acc_cnt = 0; ptr_m = 0;
      for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
      return;
    end
    done = (phase == 2) && (pready || acc_cnt == TO - 1);
    arb  = (phase == 0) || done;
    if (done)
      exp_q.push_back('{cur.id, (pready && !cur.w) ? prdata : '0, pready ? pslverr : 1'b1, $time});
    w  = -1;
    eg = '0;
    if (arb)
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr_m + k) % N;
        if (w < 0 && pend_v[c]) w = c;
      end
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt", gnt, eg);
    if (w >= 0) begin
      cur = pend[w]; ptr_m = (w + 1) % N; phase = 1; acc_cnt = 0;
      if ($urandom_range(99) >= hold_pct) pend_v[w] = 1'b0;
    end else if (arb) phase = 0;
    else if (phase == 1) begin phase = 2; acc_cnt = 0; end
    else acc_cnt++;
  endtask

  // Response monitor: independent of stimulus, drains the expected queue.
  initial forever begin
    @(negedge clk);
    if (exp_q.size() != 0 && $time > exp_q[0].t + 9) begin
      checks++; errors++;
      $display("FAIL rsp_missing actual=none required=id%0d", exp_q[0].id);
      void'(exp_q.pop_front());
    end
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected actual=%b required=none", rsp_valid);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_valid", rsp_valid, 64'd1 << e.id);
        chk("rsp_time", $time, e.t + 9);
        chk("rsp_rdata", rsp_rdata, e.rd);
        chk("rsp_err", rsp_err, e.err);
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; addr = '0; we = '0; wdata = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", psel, 0);        chk("rst_penable", penable, 0);
    chk("rst_gnt", gnt, 0);          chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);  chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_paddr", paddr, 0);      chk("rst_pwrite", pwrite, 0);
    chk("rst_pwdata", pwdata, 0);
    rst = 1'b0;

    // Zero-wait single write.
    mk(0, 32'h100, 1'b1, 32'hCAFE);
    repeat (6) cycle();
    // Read with wait states.
    rdy_pct = 30;
    mk(1, 32'h204, 1'b0, 32'h0);
    repeat (12) cycle();
    // Hung slave: timeout abort.
    rdy_pct = 0;
    mk(2, 32'h308, 1'b0, 32'h0);
    repeat (8) cycle();
    // Slave error followed by a clean transfer.
    rdy_pct = 100; err_pct = 100;
    mk(1, 32'h40C, 1'b1, 32'h55);
    repeat (3) cycle();
    err_pct = 0;
    mk(0, 32'h410, 1'b0, 32'h0);
    repeat (6) cycle();
    // All requesters held: strict rotation, psel continuous.
    req_pct = 100; hold_pct = 100;
    repeat (14) cycle();
    // Randomised traffic.
    req_pct = 30; rdy_pct = 60; err_pct = 15; hold_pct = 20; wd_pct = 3;
    repeat (3000) cycle();

    // Reset in the middle of an ACCESS phase.
    req_pct = 0; hold_pct = 0; wd_pct = 0; err_pct = 0; rdy_pct = 100;
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    repeat (8) cycle();
    rdy_pct = 0;
    mk(2, 32'h500, 1'b1, 32'h77);
    for (int i = 0; i < 6 && phase != 2; i++) cycle();
    chk("reach_access", phase, 2);
    cycle(1'b1);
    rdy_pct = 100;
    for (int i = 0; i < N; i++) mk(i, 32'h600 + i, 1'b0, 32'h0);
    repeat (10) cycle();

    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    repeat (8) cycle();
    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
